// File: rtl/dungv_isa_pkg.sv
// Shared DungV ISA definitions: class flags, EXT/memory sub-op codes and field bit positions.
// Used by both the instruction decoder and the instruction encoder.
package dungv_isa_pkg;

    typedef enum logic [1:0] {
        FLAG_NOP = 2'd0,
        FLAG_ALU = 2'd1,
        FLAG_EXT = 2'd2,
        FLAG_MEM = 2'd3
    } flag_e;

    localparam logic [3:0] OPER_EXT_REG = 4'd2;
    localparam logic [3:0] OPER_EXT_IMM = 4'd3;

    // mem_op 1/2 carry a register, 0/3 carry an immediate
    localparam logic [1:0] MEM_OP_IMM_0 = 2'd0;
    localparam logic [1:0] MEM_OP_REG_1 = 2'd1;
    localparam logic [1:0] MEM_OP_REG_2 = 2'd2;
    localparam logic [1:0] MEM_OP_IMM_3 = 2'd3;

    localparam int FLAG_MSB    = 31;
    localparam int FLAG_LSB    = 30;

    localparam int OPER_MSB    = 29;
    localparam int OPER_LSB    = 26;
    localparam int RR_RA_MSB   = 25;
    localparam int RR_RA_LSB   = 20;
    localparam int RR_RB_MSB   = 19;
    localparam int RR_RB_LSB   = 14;
    localparam int RI_IMM_MSB  = 19;
    localparam int RI_IMM_LSB  = 4;

    localparam int MEM_OP_MSB  = 29;
    localparam int MEM_OP_LSB  = 28;
    localparam int MR_RA_MSB   = 27;
    localparam int MR_RA_LSB   = 22;
    localparam int MR_ADDR_MSB = 21;
    localparam int MR_ADDR_LSB = 12;
    localparam int MI_ADDR_MSB = 27;
    localparam int MI_ADDR_LSB = 18;
    localparam int MI_IMM_MSB  = 17;
    localparam int MI_IMM_LSB  = 2;

endpackage

// File: rtl/instr_enc_buf.sv
// Two-entry FIFO holding packed {instr, pc} words; head visible the cycle after a push into empty.
// Push ignored when full, pop ignored when empty; count exported so the parent derives ready/valid.
module instr_enc_buf #(
    parameter int             W       = 42,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok  = push && (count != 2'd2);
    assign pop_ok   = pop  && (count != 2'd0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= RST_VAL;
            mem[1] <= RST_VAL;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encode.sv
// Packs DungV field bundles into 32-bit words, NOPs illegal ones, tags each with a sequential pc.
// Latency 1 cycle into a 2-entry buffer; in_ready depends only on the registered buffer count.
module instr_encode
    import dungv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_flag,
    input  logic [3:0]        in_oper,
    input  logic [5:0]        in_rega,
    input  logic [5:0]        in_regb,
    input  logic [15:0]       in_intermed,
    input  logic [1:0]        in_mem_op,
    input  logic [9:0]        in_mem_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              illegal,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam int                PW   = 32 + ADDR_W;

    logic [31:0]       word;
    logic              word_ill;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [ADDR_W-1:0] pc_next;
    logic [PW-1:0]     head_dat;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = head_dat[PW-1:ADDR_W];
    assign out_pc    = head_dat[ADDR_W-1:0];

    always_comb begin
        word     = '0;
        word_ill = 1'b0;
        word[FLAG_MSB:FLAG_LSB] = in_flag;
        case (flag_e'(in_flag))
            FLAG_ALU: begin
                word[OPER_MSB:OPER_LSB]   = in_oper;
                word[RR_RA_MSB:RR_RA_LSB] = in_rega;
                word[RR_RB_MSB:RR_RB_LSB] = in_regb;
            end
            FLAG_EXT: begin
                word[OPER_MSB:OPER_LSB]   = in_oper;
                word[RR_RA_MSB:RR_RA_LSB] = in_rega;
                if (in_oper == OPER_EXT_REG) begin
                    word[RR_RB_MSB:RR_RB_LSB] = in_regb;
                end else if (in_oper == OPER_EXT_IMM) begin
                    word[RI_IMM_MSB:RI_IMM_LSB] = in_intermed;
                end else begin
                    word_ill = 1'b1;
                end
            end
            FLAG_MEM: begin
                word[MEM_OP_MSB:MEM_OP_LSB] = in_mem_op;
                if (in_mem_op == MEM_OP_REG_1 || in_mem_op == MEM_OP_REG_2) begin
                    word[MR_RA_MSB:MR_RA_LSB]     = in_rega;
                    word[MR_ADDR_MSB:MR_ADDR_LSB] = in_mem_addr;
                end else begin
                    word[MI_ADDR_MSB:MI_ADDR_LSB] = in_mem_addr;
                    word[MI_IMM_MSB:MI_IMM_LSB]   = in_intermed;
                end
            end
            default: word = '0;
        endcase
        // an illegal bundle still consumes a pc slot but is emitted as NOP
        if (word_ill) begin
            word = '0;
        end
    end

    instr_enc_buf #(
        .W       (PW),
        .RST_VAL ({32'h0, BASE})
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({word, pc_next}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next   <= BASE;
            illegal   <= 1'b0;
            err_count <= '0;
        end else begin
            illegal <= push && word_ill;
            if (push) begin
                pc_next <= pc_next + ADDR_W'(1);
                if (word_ill && err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Randomized and directed bench for instr_encode against a queue-based reference model.
module tb_instr_encode;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 5;
    localparam int ERR_W     = 8;
    localparam int ERR_MAX   = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_flag;
    logic [3:0]        in_oper;
    logic [5:0]        in_rega;
    logic [5:0]        in_regb;
    logic [15:0]       in_intermed;
    logic [1:0]        in_mem_op;
    logic [9:0]        in_mem_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              illegal;
    logic [ERR_W-1:0]  err_count;

    instr_encode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .ERR_W     (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_flag     (in_flag),
        .in_oper     (in_oper),
        .in_rega     (in_rega),
        .in_regb     (in_regb),
        .in_intermed (in_intermed),
        .in_mem_op   (in_mem_op),
        .in_mem_addr (in_mem_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .illegal     (illegal),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          pc;
    } ent_t;

    ent_t q[$];
    int   m_pc;
    int   m_err;
    bit   m_ill;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected word straight from the format table, with plain shifts
    function automatic logic [31:0] ref_word(input int f, input int op, input int ra, input int rb,
                                             input int imm, input int mop, input int ma,
                                             output bit ill);
        logic [31:0] w;
        ill = 1'b0;
        w   = 32'h0;
        if (f == 1) begin
            w = (32'd1 << 30) | (32'(op) << 26) | (32'(ra) << 20) | (32'(rb) << 14);
        end else if (f == 2 && op == 2) begin
            w = (32'd2 << 30) | (32'(op) << 26) | (32'(ra) << 20) | (32'(rb) << 14);
        end else if (f == 2 && op == 3) begin
            w = (32'd2 << 30) | (32'(op) << 26) | (32'(ra) << 20) | (32'(imm) << 4);
        end else if (f == 2) begin
            ill = 1'b1;
        end else if (f == 3 && (mop == 1 || mop == 2)) begin
            w = (32'd3 << 30) | (32'(mop) << 28) | (32'(ra) << 22) | (32'(ma) << 12);
        end else if (f == 3) begin
            w = (32'd3 << 30) | (32'(mop) << 28) | (32'(ma) << 18) | (32'(imm) << 2);
        end
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc  = BASE_ADDR;
        m_err = 0;
        m_ill = 1'b0;
    endtask

    task automatic set_bundle(input int f, input int op, input int ra, input int rb,
                              input int imm, input int mop, input int ma);
        in_flag     = 2'(f);
        in_oper     = 4'(op);
        in_rega     = 6'(ra);
        in_regb     = 6'(rb);
        in_intermed = 16'(imm);
        in_mem_op   = 2'(mop);
        in_mem_addr = 10'(ma);
    endtask

    task automatic rand_bundle();
        int op;
        op = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 15);
        set_bundle($urandom_range(0, 3), op, $urandom_range(0, 63), $urandom_range(0, 63),
                   $urandom_range(0, 65535), $urandom_range(0, 3), $urandom_range(0, 1023));
    endtask

    // Called #1 after a rising edge: check outputs, then advance one cycle and the model
    task automatic step();
        bit          ill;
        bit          acc;
        bit          pop;
        logic [31:0] w;
        chk("in_ready", in_ready, q.size() != 2);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_pc", out_pc, q[0].pc);
        end
        chk("illegal", illegal, m_ill);
        chk("err_count", err_count, m_err);
        acc = in_valid && (q.size() != 2);
        pop = (q.size() != 0) && out_ready;
        w   = ref_word(in_flag, in_oper, in_rega, in_regb, in_intermed, in_mem_op, in_mem_addr, ill);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        m_ill = acc && ill;
        if (acc) begin
            q.push_back('{instr: w, pc: m_pc});
            m_pc = (m_pc + 1) % (1 << ADDR_W);
            if (ill && m_err < ERR_MAX) m_err++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_instr"}, out_instr, 32'h0);
        chk({tag, "_out_pc"}, out_pc, BASE_ADDR);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_bundle(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #22;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed format vectors, each accepted into an empty buffer
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_bundle(1, 5, 3, 7, 16'h1234, 2, 10'h155);
        step();
        chk("alu_word", out_instr, 32'h5431C000);
        chk("alu_pc", out_pc, BASE_ADDR);
        set_bundle(2, 3, 1, 9, 16'hBEEF, 1, 10'h2AA);
        step();
        chk("ext_imm_word", out_instr, 32'h8C1BEEF0);
        set_bundle(3, 1, 2, 5, 16'hFFFF, 1, 10'h3FF);
        step();
        chk("mem_reg_word", out_instr, 32'hD0BFF000);
        set_bundle(2, 7, 4, 4, 16'hAAAA, 3, 10'h001);
        step();
        chk("ill_word", out_instr, 32'h0);
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_count", err_count, 1);
        in_valid = 1'b0;
        step();
        chk("ill_pulse_end", illegal, 1'b0);

        // Saturate the error counter
        in_valid = 1'b1;
        set_bundle(2, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step();
        chk("err_sat", err_count, ERR_MAX);

        // Backpressure: three bundles offered against a stalled consumer
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_bundle(1, i + 1, i, i, 0, 0, 0);
            step();
        end
        chk("bp_full_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Back-to-back stream across the pc wrap
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rand_bundle();
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_bundle();
            step();
        end

        // Fill the buffer, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4 && q.size() != 2; i++) begin
            rand_bundle();
            step();
        end
        chk("pre_rst_full", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_bundle(1, 9, 1, 2, 0, 0, 0);
        step();
        chk("post_rst_pc", out_pc, BASE_ADDR);
        in_valid = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
